// File: rtl/octal_rr_arbiter_if.sv
// Interface bundling the octal_rr_arbiter request/grant signals.
// master: the requester side (drives req/done, observes the grant).
// slave:  the arbiter itself.
interface octal_rr_arbiter_if #(
  parameter int CNT_W = 8
);
  logic [7:0]       req;
  logic             done;
  logic [2:0]       sel;
  logic             sel_en;
  logic [7:0]       gnt;
  logic             busy;
  logic             timeout;
  logic [CNT_W-1:0] gcount;

  modport master (
    output req, done,
    input  sel, sel_en, gnt, busy, timeout, gcount
  );

  modport slave (
    input  req, done,
    output sel, sel_en, gnt, busy, timeout, gcount
  );
endinterface

// File: rtl/octal_rr_arbiter.sv
// 8-way round-robin arbiter owning the shared 3-to-8 decoder path.
// sel/sel_en drive the decoder A/EN pins; gnt is a one-hot local copy.
// A grant is held until the owner raises done or drops its request, and
// every handover passes through exactly one idle cycle so the decoder
// never sees the owner change in a single edge.
// Optional feature macro: ARB_TIMEOUT_EN -- force-release a grant held
// for HOLD_MAX cycles and pulse timeout. Without it, timeout is tied low.
module octal_rr_arbiter #(
  parameter int HOLD_MAX = 15,
  parameter int CNT_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  octal_rr_arbiter_if.slave   bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state_reg;
  logic [2:0]       ptr_reg;
  logic [2:0]       sel_reg;
  logic             sel_en_reg;
  logic [7:0]       gnt_reg;
  logic             busy_reg;
  logic [CNT_W-1:0] gcount_reg;

  // A hold limit below one cycle is meaningless; reject it at elaboration.
  if (HOLD_MAX < 1) begin : g_bad_hold
    $error("octal_rr_arbiter: HOLD_MAX must be at least 1");
  end

  // Request vector rotated so that bit k is requester (ptr + k) mod 8.
  logic [14:0] req_dbl;
  logic [7:0]  req_rot;
  logic [2:0]  pick_off;
  logic        pick_valid;
  logic [2:0]  pick_idx;

  assign req_dbl = {bus.req[6:0], bus.req};
  assign req_rot = req_dbl[ptr_reg +: 8];

  // Lowest set bit of the rotated vector is the next owner after ptr.
  always_comb begin
    pick_valid = 1'b0;
    pick_off   = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (req_rot[k]) begin
        pick_valid = 1'b1;
        pick_off   = 3'(k);
      end
    end
  end

  assign pick_idx = ptr_reg + pick_off;

  // Normal release: owner finished or withdrew its request.
  logic rel_now;
  assign rel_now = bus.done || !bus.req[sel_reg];

`ifdef ARB_TIMEOUT_EN
  localparam int HOLD_W = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_MAX - 1);

  logic [HOLD_W-1:0] hold_reg;
  logic              timeout_reg;
  logic              hold_hit;

  assign hold_hit = (hold_reg == HOLD_LAST);

  // Hold counter: cleared when a grant starts, counts each grant cycle;
  // timeout pulses only when the limit, not the owner, ended the grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_reg    <= '0;
      timeout_reg <= 1'b0;
    end else begin
      timeout_reg <= 1'b0;
      if (state_reg == IDLE) begin
        hold_reg <= '0;
      end else if (!rel_now && hold_hit) begin
        timeout_reg <= 1'b1;
      end else if (!rel_now) begin
        hold_reg <= hold_reg + 1'b1;
      end
    end
  end

  assign bus.timeout = timeout_reg;
`else
  logic hold_hit;
  assign hold_hit    = 1'b0;
  assign bus.timeout = 1'b0;
`endif

  // Arbitration FSM with registered decoder/grant outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      ptr_reg    <= 3'd0;
      sel_reg    <= 3'd0;
      sel_en_reg <= 1'b0;
      gnt_reg    <= 8'h00;
      busy_reg   <= 1'b0;
      gcount_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (pick_valid) begin
            state_reg  <= GRANT;
            sel_reg    <= pick_idx;
            sel_en_reg <= 1'b1;
            gnt_reg    <= 8'd1 << pick_idx;
            busy_reg   <= 1'b1;
            gcount_reg <= gcount_reg + 1'b1;
          end
        end
        GRANT: begin
          // sel keeps its last value through the turnaround cycle.
          if (rel_now || hold_hit) begin
            state_reg  <= IDLE;
            sel_en_reg <= 1'b0;
            gnt_reg    <= 8'h00;
            busy_reg   <= 1'b0;
            ptr_reg    <= sel_reg + 3'd1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.sel    = sel_reg;
  assign bus.sel_en = sel_en_reg;
  assign bus.gnt    = gnt_reg;
  assign bus.busy   = busy_reg;
  assign bus.gcount = gcount_reg;

endmodule

// File: tb/tb_octal_rr_arbiter.sv
// Directed testbench for octal_rr_arbiter. Expectations adapt to whether
// ARB_TIMEOUT_EN is defined (HOLD_MAX=4 in that build).
`timescale 1ns/1ps
module tb_octal_rr_arbiter;

`ifdef ARB_TIMEOUT_EN
  localparam int HOLD_MAX = 4;
`else
  localparam int HOLD_MAX = 15;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  octal_rr_arbiter_if #(.CNT_W(8)) bus ();

  octal_rr_arbiter #(.HOLD_MAX(HOLD_MAX), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Packed view: {sel_en, sel[2:0], gnt[7:0], busy, timeout}
  logic [13:0] obs;
  assign obs = {bus.sel_en, bus.sel, bus.gnt, bus.busy, bus.timeout};

  // Advance one clock; outputs are then sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req = 8'hFF;
    bus.done = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (obs !== 14'd0 || bus.gcount !== 8'd0) begin
        errors++;
        $display("FAIL reset_hold[%0d]: got obs=%h gcount=%0d, need obs=0 gcount=0", i, obs, bus.gcount);
      end
    end
    rst = 1'b0;
    bus.req = 8'h00;
    step();
    checks++;
    if (obs !== 14'd0 || bus.gcount !== 8'd0) begin
      errors++;
      $display("FAIL reset_idle: got obs=%h gcount=%0d, need obs=0 gcount=0", obs, bus.gcount);
    end
    $display("reset done");
  endtask

  task automatic test_basic_grant();
    bus.req = 8'b0010_0100;
    step();
    checks++;
    if (obs !== {1'b1, 3'd2, 8'h04, 1'b1, 1'b0} || bus.gcount !== 8'd1) begin
      errors++;
      $display("FAIL basic_first: got obs=%h gcount=%0d, need sel=2 gnt=04 gcount=1", obs, bus.gcount);
    end
    // Other request bits changing during the grant must not disturb it.
    bus.req = 8'b0010_0101;
    step();
    checks++;
    if (obs !== {1'b1, 3'd2, 8'h04, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL basic_ignore_other: got obs=%h, need sel=2 gnt=04", obs);
    end
    bus.done = 1'b1;
    step();
    bus.done = 1'b0;
    checks++;
    if (obs !== {1'b0, 3'd2, 8'h00, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL basic_turnaround: got obs=%h, need sel_en=0 sel=2 gnt=0", obs);
    end
    step();
    checks++;
    if (obs !== {1'b1, 3'd5, 8'h20, 1'b1, 1'b0} || bus.gcount !== 8'd2) begin
      errors++;
      $display("FAIL basic_second: got obs=%h gcount=%0d, need sel=5 gnt=20 gcount=2", obs, bus.gcount);
    end
    $display("grant sel=%0d gnt=%h", bus.sel, bus.gnt);
    bus.done = 1'b1;
    step();
    bus.done = 1'b0;
    bus.req = 8'h00;
    step();
  endtask

  task automatic test_fairness();
    // Fresh reset so the pointer starts at 0.
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.req = 8'hFF;
    bus.done = 1'b1;   // held high: ignored in IDLE, releases each grant
    for (int i = 0; i < 9; i++) begin
      step();
      checks++;
      if (bus.sel !== 3'(i % 8) || bus.gnt !== (8'd1 << (i % 8)) || bus.sel_en !== 1'b1 ||
          bus.gcount !== 8'(i + 1)) begin
        errors++;
        $display("FAIL fair_grant[%0d]: got sel=%0d gnt=%h gcount=%0d, need sel=%0d gcount=%0d",
                 i, bus.sel, bus.gnt, bus.gcount, i % 8, i + 1);
      end
      $display("grant %0d sel=%0d gcount=%0d", i, bus.sel, bus.gcount);
      step();
      checks++;
      if (bus.gnt !== 8'h00 || bus.sel_en !== 1'b0 || bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL fair_gap[%0d]: got gnt=%h sel_en=%b busy=%b, need all 0", i, bus.gnt, bus.sel_en, bus.busy);
      end
    end
    bus.done = 1'b0;
    bus.req = 8'h00;
    step();
    // pointer is now 1
  endtask

  task automatic test_wrap();
    bus.req = 8'h81;
    step();
    checks++;
    if (bus.sel !== 3'd7 || bus.gnt !== 8'h80) begin
      errors++;
      $display("FAIL wrap_seven: got sel=%0d gnt=%h, need sel=7 gnt=80", bus.sel, bus.gnt);
    end
    bus.done = 1'b1;
    step();
    bus.done = 1'b0;
    step();
    checks++;
    if (bus.sel !== 3'd0 || bus.gnt !== 8'h01) begin
      errors++;
      $display("FAIL wrap_zero: got sel=%0d gnt=%h, need sel=0 gnt=01", bus.sel, bus.gnt);
    end
    // Owner dropping its request also releases.
    bus.req = 8'h00;
    step();
    checks++;
    if (obs !== {1'b0, 3'd0, 8'h00, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL wrap_req_drop: got obs=%h, need idle with sel=0", obs);
    end
    $display("wrap done");
    // pointer is now 1
  endtask

  task automatic test_timeout();
    bus.req = 8'h08;
    bus.done = 1'b0;
    step();
    checks++;
    if (obs !== {1'b1, 3'd3, 8'h08, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL hold_first: got obs=%h, need sel=3 gnt=08", obs);
    end
`ifdef ARB_TIMEOUT_EN
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (obs !== {1'b1, 3'd3, 8'h08, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL hold_cycle[%0d]: got obs=%h, need sel=3 gnt=08", i, obs);
      end
    end
    step();
    checks++;
    if (obs !== {1'b0, 3'd3, 8'h00, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL hold_timeout: got obs=%h, need idle with timeout=1", obs);
    end
    step();
    checks++;
    if (obs !== {1'b1, 3'd3, 8'h08, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL hold_regrant: got obs=%h, need sel=3 gnt=08 timeout=0", obs);
    end
    // done coinciding with the limit edge is a normal release.
    for (int i = 0; i < 3; i++) step();
    bus.done = 1'b1;
    step();
    bus.done = 1'b0;
    checks++;
    if (obs !== {1'b0, 3'd3, 8'h00, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL hold_done_coincide: got obs=%h, need idle with timeout=0", obs);
    end
`else
    for (int i = 0; i < 110; i++) begin
      step();
      checks++;
      if (obs !== {1'b1, 3'd3, 8'h08, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL hold_forever[%0d]: got obs=%h, need sel=3 gnt=08 timeout=0", i, obs);
      end
    end
`endif
    bus.req = 8'h00;
    step();
    checks++;
    if (bus.gnt !== 8'h00 || bus.timeout !== 1'b0) begin
      errors++;
      $display("FAIL hold_release: got gnt=%h timeout=%b, need 0/0", bus.gnt, bus.timeout);
    end
    $display("timeout scenario done");
    // pointer is now 4
  endtask

  task automatic test_reset_mid_grant();
    bus.req = 8'h40;
    step();
    checks++;
    if (bus.sel !== 3'd6 || bus.gnt !== 8'h40) begin
      errors++;
      $display("FAIL midrst_grant: got sel=%0d gnt=%h, need sel=6 gnt=40", bus.sel, bus.gnt);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (obs !== 14'd0 || bus.gcount !== 8'd0) begin
      errors++;
      $display("FAIL midrst_clear: got obs=%h gcount=%0d, need 0/0", obs, bus.gcount);
    end
    bus.req = 8'hC0;
    step();
    checks++;
    if (bus.sel !== 3'd6 || bus.gnt !== 8'h40 || bus.gcount !== 8'd1) begin
      errors++;
      $display("FAIL midrst_ptr0: got sel=%0d gnt=%h gcount=%0d, need sel=6 gnt=40 gcount=1",
               bus.sel, bus.gnt, bus.gcount);
    end
    $display("mid-grant reset done");
  endtask

  initial begin
    bus.req = 8'h00;
    bus.done = 1'b0;
    test_reset();
    test_basic_grant();
    test_fairness();
    test_wrap();
    test_timeout();
    test_reset_mid_grant();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
